// File: rtl/bitq_pkg.sv
// Shared types and helpers for the bit-granular packing/unpacking queues.
// Lane masks are MSB-first: index 0 is the first bit of a field.
package bitq_pkg;

  typedef enum logic [0:0] {
    PK_FILL  = 1'b0,
    PK_FLUSH = 1'b1
  } packer_state_e;

  // Widest lane any lane_mask caller may request.
  localparam int unsigned LANE_MAX = 256;

  // Ones at indices [0:min(cnt,width)-1], zeros elsewhere.
  function automatic logic [0:LANE_MAX-1] lane_mask(input int unsigned cnt,
                                                    input int unsigned width);
    int unsigned n;
    n = (cnt > width) ? width : cnt;
    return ~({LANE_MAX{1'b1}} >> n);
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Variable-length bit-field packer: appends left-aligned fields MSB-first into an
// accumulator and emits fixed OUT_WIDTH words, with a flush that drains a tail word.
module bit_packer
  import bitq_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 64,
  parameter int unsigned ACC_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_cnt,
  input  logic [0:IN_WIDTH-1]  in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:OUT_WIDTH-1] out_data,
  output logic [31:0]          out_cnt,
  output logic [31:0]          used_cnt,
  output logic                 flush_done
);

  localparam int unsigned CNT_W = $clog2(ACC_WIDTH + 1);
  localparam logic [CNT_W-1:0] L_IN   = CNT_W'(IN_WIDTH);
  localparam logic [CNT_W-1:0] L_OUT  = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] L_ROOM = CNT_W'(ACC_WIDTH - IN_WIDTH);

  // Sizing: any fill below one output word must still leave room for a full beat.
  if (ACC_WIDTH < IN_WIDTH + OUT_WIDTH - 1) begin : g_bad_acc_width
    $fatal(1, "bit_packer: ACC_WIDTH must be >= IN_WIDTH + OUT_WIDTH - 1");
  end
  if ((IN_WIDTH > LANE_MAX) || (OUT_WIDTH > LANE_MAX)) begin : g_bad_lane_width
    $fatal(1, "bit_packer: IN_WIDTH/OUT_WIDTH exceed bitq_pkg::LANE_MAX");
  end

  packer_state_e              r_state;
  logic [0:ACC_WIDTH-1]       r_acc;
  logic [CNT_W-1:0]           r_fill;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [0:OUT_WIDTH-1]       r_out_data;
  logic [CNT_W-1:0]           r_out_cnt;
  logic                       r_flush_done;

  logic                       w_push;
  logic [CNT_W-1:0]           w_cnt_eff;
  logic [CNT_W-1:0]           w_push_cnt;
  logic [CNT_W-1:0]           w_pop_cnt;
  logic [CNT_W-1:0]           w_fill_mid;
  logic [0:IN_WIDTH-1]        w_in_masked;
  logic [0:ACC_WIDTH-1]       w_acc_n;
  logic [CNT_W-1:0]           w_fill_n;
  packer_state_e              w_state_n;
  logic [CNT_W-1:0]           w_out_cnt_n;
  logic                       w_out_valid_n;
  logic [0:OUT_WIDTH-1]       w_out_data_n;
  logic                       w_in_ready_n;
  logic                       w_flush_done_n;

  // Shift out the popped word, insert the masked beat behind what remains, then
  // derive next-cycle outputs from the next state so every output is a flop.
  always_comb begin
    w_pop_cnt   = (r_out_valid && out_ready) ? r_out_cnt : '0;
    w_push      = in_valid && r_in_ready;
    w_cnt_eff   = (in_cnt > 32'(IN_WIDTH)) ? L_IN : CNT_W'(in_cnt);
    w_push_cnt  = w_push ? w_cnt_eff : '0;
    w_in_masked = in_data &
                  IN_WIDTH'(lane_mask(32'(w_push_cnt), IN_WIDTH) >> (LANE_MAX - IN_WIDTH));
    w_fill_mid  = r_fill - w_pop_cnt;
    w_acc_n     = (r_acc << w_pop_cnt) |
                  ({w_in_masked, {(ACC_WIDTH - IN_WIDTH){1'b0}}} >> w_fill_mid);
    w_fill_n    = w_fill_mid + w_push_cnt;

    w_state_n = r_state;
    case (r_state)
      PK_FILL:  if (flush) w_state_n = PK_FLUSH;
      PK_FLUSH: if (r_fill == '0) w_state_n = PK_FILL;
      default:  w_state_n = PK_FILL;
    endcase

    w_out_cnt_n = '0;
    if (w_fill_n >= L_OUT) begin
      w_out_cnt_n = L_OUT;
    end else if (w_state_n == PK_FLUSH) begin
      w_out_cnt_n = w_fill_n;
    end
    w_out_valid_n  = (w_out_cnt_n != '0);
    w_out_data_n   = w_acc_n[0:OUT_WIDTH-1] &
                     OUT_WIDTH'(lane_mask(32'(w_out_cnt_n), OUT_WIDTH) >> (LANE_MAX - OUT_WIDTH));
    w_in_ready_n   = (w_state_n == PK_FILL) && (w_fill_n <= L_ROOM);
    w_flush_done_n = (w_state_n == PK_FLUSH) && (w_fill_n == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= PK_FILL;
      r_acc        <= '0;
      r_fill       <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_cnt    <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_acc        <= w_acc_n;
      r_fill       <= w_fill_n;
      r_in_ready   <= w_in_ready_n;
      r_out_valid  <= w_out_valid_n;
      r_out_data   <= w_out_data_n;
      r_out_cnt    <= w_out_cnt_n;
      r_flush_done <= w_flush_done_n;
    end
  end

  // An oversized field on an accepted beat is a producer bug, not a recoverable case.
  always_ff @(posedge clk) begin
    if (reset && in_valid && r_in_ready && (in_cnt > 32'(IN_WIDTH))) begin
      $fatal(1, "bit_packer: in_cnt %0d exceeds IN_WIDTH %0d", in_cnt, IN_WIDTH);
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_cnt    = 32'(r_out_cnt);
  assign used_cnt   = 32'(r_fill);
  assign flush_done = r_flush_done;

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: directed vector table, hand-written corner
// sequences, and randomized traffic against a bit-queue reference model.
module tb_bit_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_cnt;
  logic [0:63] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_data;
  logic [31:0] out_cnt;
  logic [31:0] used_cnt;
  logic        flush_done;

  bit_packer #(.IN_WIDTH(64), .OUT_WIDTH(64), .ACC_WIDTH(128)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt),
    .used_cnt(used_cnt), .flush_done(flush_done)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: the accumulator is just a queue of bits plus a draining flag.
  bit mq[$];
  bit mfl;

  function automatic int m_cnt();
    if (mq.size() >= 64) return 64;
    if (mfl && mq.size() > 0) return mq.size();
    return 0;
  endfunction

  function automatic logic [63:0] m_data();
    logic [63:0] r = '0;
    for (int i = 0; i < m_cnt(); i++) r[63-i] = mq[i];
    return r;
  endfunction

  function automatic bit m_ready();
    return !mfl && (128 - mq.size() >= 64);
  endfunction

  function automatic void m_update(input logic rs, input logic iv, input int c,
                                   input logic [63:0] d, input logic fl, input logic ordy);
    int  pc;
    bit  acc;
    bit  was_fl;
    int  pre;
    if (!rs) begin
      mq.delete();
      mfl = 1'b0;
      return;
    end
    pc     = ordy ? m_cnt() : 0;
    acc    = iv && m_ready();
    was_fl = mfl;
    pre    = mq.size();
    for (int i = 0; i < pc; i++) void'(mq.pop_front());
    if (acc) for (int i = 0; i < c; i++) mq.push_back(d[63-i]);
    if (!was_fl) mfl = fl;
    else if (pre == 0) mfl = 1'b0;
  endfunction

  // Drive one cycle (from a negedge), advance the model, return at the next negedge.
  task automatic cyc(input logic rs, input logic iv, input int c, input logic [63:0] d,
                     input logic fl, input logic ordy);
    reset = rs; in_valid = iv; in_cnt = 32'(c); in_data = d; flush = fl; out_ready = ordy;
    @(posedge clk);
    m_update(rs, iv, c, d, fl, ordy);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ov"},   64'(out_valid),  64'(m_cnt() > 0));
    chk({tag, ".ocnt"}, 64'(out_cnt),    64'(m_cnt()));
    chk({tag, ".odat"}, out_data,        m_data());
    chk({tag, ".ir"},   64'(in_ready),   64'(m_ready()));
    chk({tag, ".used"}, 64'(used_cnt),   64'(mq.size()));
    chk({tag, ".fd"},   64'(flush_done), 64'(mfl && mq.size() == 0));
  endtask

  typedef struct {
    logic rs; logic iv; int cnt; logic [63:0] d; logic fl; logic ordy;
    logic ov; int ocnt; logic [63:0] od; int used; logic ir; logic fd;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic iv, input int cnt,
                              input logic [63:0] d, input logic fl, input logic ordy,
                              input logic ov, input int ocnt, input logic [63:0] od,
                              input int used, input logic ir, input logic fd);
    vec_t v;
    v.rs = rs; v.iv = iv; v.cnt = cnt; v.d = d; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.ocnt = ocnt; v.od = od; v.used = used; v.ir = ir; v.fd = fd;
    return v;
  endfunction

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int NV = 16;
  vec_t tbl[NV];

  initial begin
    logic [63:0] b1, b2, a, exp_tail;
    logic        rs;
    string       tag;

    // Each row: inputs for one cycle, then the outputs expected right after it.
    tbl[0]  = mk(0,0, 0,64'h0,0,0,                 0, 0,64'h0,                 0,1,0);
    tbl[1]  = mk(0,1,64,ONES,1,1,                  0, 0,64'h0,                 0,1,0);
    tbl[2]  = mk(1,1,24,64'hABCDEF0000000000,0,1,  0, 0,64'h0,                24,1,0);
    tbl[3]  = mk(1,1,40,64'h1234567890ABCDEF,0,1,  1,64,64'hABCDEF1234567890,64,1,0);
    tbl[4]  = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,1,0);
    tbl[5]  = mk(1,1, 8,ONES,0,1,                  0, 0,64'h0,                 8,1,0);
    tbl[6]  = mk(1,0, 0,64'h0,1,1,                 1, 8,64'hFF00000000000000,  8,0,0);
    tbl[7]  = mk(1,0, 0,64'h0,0,0,                 1, 8,64'hFF00000000000000,  8,0,0);
    tbl[8]  = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,0,1);
    tbl[9]  = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,1,0);
    tbl[10] = mk(1,0, 0,64'h0,1,1,                 0, 0,64'h0,                 0,0,1);
    tbl[11] = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,1,0);
    tbl[12] = mk(1,1, 0,ONES,0,1,                  0, 0,64'h0,                 0,1,0);
    tbl[13] = mk(1,1, 4,64'hAFFFFFFFFFFFFFFF,1,0,  1, 4,64'hA000000000000000,  4,0,0);
    tbl[14] = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,0,1);
    tbl[15] = mk(1,0, 0,64'h0,0,1,                 0, 0,64'h0,                 0,1,0);

    reset = 1'b0; in_valid = 1'b0; in_cnt = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    mfl = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rs, tbl[i].iv, tbl[i].cnt, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      tag = $sformatf("v%0d", i);
      chk({tag, ".ov"},   64'(out_valid),  64'(tbl[i].ov));
      chk({tag, ".ocnt"}, 64'(out_cnt),    64'(tbl[i].ocnt));
      chk({tag, ".odat"}, out_data,        tbl[i].od);
      chk({tag, ".used"}, 64'(used_cnt),   64'(tbl[i].used));
      chk({tag, ".ir"},   64'(in_ready),   64'(tbl[i].ir));
      chk({tag, ".fd"},   64'(flush_done), 64'(tbl[i].fd));
    end

    // Backpressure: two full beats held, then drained in order.
    b1 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    cyc(1, 1, 64, b1, 0, 0);
    cyc(1, 1, 64, b2, 0, 0);
    chk("bp.used", 64'(used_cnt), 64'd128);
    chk("bp.ir",   64'(in_ready), 64'd0);
    chk("bp.ov",   64'(out_valid), 64'd1);
    chk("bp.hold", out_data, b1);
    cyc(1, 1, 64, ONES, 0, 0);
    chk("bp.hold2", out_data, b1);
    chk("bp.used2", 64'(used_cnt), 64'd128);
    cyc(1, 0, 0, 64'h0, 0, 1);
    chk("bp.w2",   out_data, b2);
    chk("bp.ir2",  64'(in_ready), 64'd1);
    chk("bp.usd3", 64'(used_cnt), 64'd64);
    cyc(1, 0, 0, 64'h0, 0, 1);
    chk("bp.empty", 64'(used_cnt), 64'd0);
    check_model("bp");

    // Pop and push in the same cycle, then flush the 6+30 bit tail.
    a = {$urandom, $urandom};
    cyc(1, 1, 64, a, 0, 0);
    chk("sim.word", out_data, a);
    cyc(1, 1, 6, 64'hB7FFFFFFFFFFFFFF, 0, 1);
    chk("sim.used6", 64'(used_cnt), 64'd6);
    chk("sim.ov6",   64'(out_valid), 64'd0);
    cyc(1, 1, 30, 64'hDEADBEEF12345678, 0, 0);
    chk("sim.used36", 64'(used_cnt), 64'd36);
    cyc(1, 0, 0, 64'h0, 1, 0);
    exp_tail = {6'b101101, 30'h37AB6FBB, 28'h0};
    chk("sim.ocnt", 64'(out_cnt), 64'd36);
    chk("sim.tail", out_data, exp_tail);
    cyc(1, 0, 0, 64'h0, 0, 1);
    chk("sim.fd", 64'(flush_done), 64'd1);
    cyc(1, 0, 0, 64'h0, 0, 1);
    check_model("sim");

    // Reset while draining a partial word.
    cyc(1, 1, 20, {$urandom, $urandom}, 0, 0);
    cyc(1, 0, 0, 64'h0, 1, 0);
    chk("rmf.ov_pre", 64'(out_valid), 64'd1);
    cyc(0, 0, 0, 64'h0, 0, 0);
    chk("rmf.ov",   64'(out_valid), 64'd0);
    chk("rmf.ir",   64'(in_ready), 64'd1);
    chk("rmf.used", 64'(used_cnt), 64'd0);
    chk("rmf.fd",   64'(flush_done), 64'd0);
    cyc(1, 0, 0, 64'h0, 0, 1);
    chk("rmf.fill_state", 64'(in_ready), 64'd1);
    chk("rmf.ov2", 64'(out_valid), 64'd0);

    // Random traffic against the model, with a two-cycle reset in the middle.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1500; i++) begin
        rs = ($urandom_range(0, 399) != 0);
        cyc(rs, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 64)),
            {$urandom, $urandom}, 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 9) < 7));
        check_model($sformatf("r%0d_%0d", pass, i));
      end
      if (pass == 0) begin
        cyc(0, 1, 64, ONES, 1, 1);
        cyc(0, 1, 64, ONES, 0, 1);
        chk("mrst.ir",   64'(in_ready), 64'd1);
        chk("mrst.ov",   64'(out_valid), 64'd0);
        chk("mrst.used", 64'(used_cnt), 64'd0);
        chk("mrst.ocnt", 64'(out_cnt), 64'd0);
        chk("mrst.fd",   64'(flush_done), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
